// File: rtl/lab2v1_pio_in_edge.sv
// lab2v1_pio_in_edge
//   Avalon-MM slave input PIO. Synchronises WIDTH external pins. It exposes
//   their live level, an edge-capture register and an IRQ mask, and raises a
//   level interrupt whenever a captured edge is unmasked.
//
//   Register map (word offsets):
//     0 DATA (RO)    synchronised pin levels
//     1      (RO)    reads 0
//     2 MASK (RW)    interrupt enable per pin
//     3 EDGE (R/W1C) captured edges; writing 1 clears a bit
//
// Ports
//   clk        system clock, all logic on posedge
//   reset      synchronous active-high reset
//   address    register select (word offset)
//   chipselect slave select
//   read_n     active-low read strobe
//   write_n    active-low write strobe
//   writedata  write data (only [WIDTH-1:0] is used)
//   in_port    asynchronous external pins
//   readdata   registered read data, latency 1
//   irq        level interrupt, |(EDGE & MASK)
module lab2v1_pio_in_edge #(
  parameter int WIDTH       = 4,
  parameter int EDGE_TYPE   = 0,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             read_n,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  localparam int CNT_W = $clog2(SYNC_STAGES + 2);
  localparam logic [CNT_W-1:0] WARM_DONE = CNT_W'(SYNC_STAGES + 1);

  logic [WIDTH-1:0] sync_p [SYNC_STAGES];
  logic [WIDTH-1:0] sync_q;
  logic [WIDTH-1:0] d1;
  logic [WIDTH-1:0] edge_raw;
  logic [WIDTH-1:0] edge_det;
  logic [WIDTH-1:0] edge_cap;
  logic [WIDTH-1:0] mask_q;
  logic [WIDTH-1:0] clr;
  logic [CNT_W-1:0] warm_cnt;
  logic             warm_done;
  logic             wr_mask;
  logic             wr_edge;
  logic             rd_en;
  logic             unused_wdata;

  // Upper write-data bits have no storage behind them.
  assign unused_wdata = &{1'b0, writedata};

  function automatic logic [31:0] zext(input logic [WIDTH-1:0] v);
    logic [31:0] r;
    r = '0;
    r[WIDTH-1:0] = v;
    return r;
  endfunction

  function automatic logic [31:0] rd_sel(input logic [1:0] a,
                                         input logic [WIDTH-1:0] data_v,
                                         input logic [WIDTH-1:0] mask_v,
                                         input logic [WIDTH-1:0] edge_v);
    logic [31:0] r;
    case (a)
      2'd0:    r = zext(data_v);
      2'd2:    r = zext(mask_v);
      2'd3:    r = zext(edge_v);
      default: r = '0;
    endcase
    return r;
  endfunction

  // Synchroniser chain and one-cycle delay for edge detection
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_p[i] <= '0;
      d1 <= '0;
    end else begin
      sync_p[0] <= in_port;
      for (int i = 1; i < SYNC_STAGES; i++) sync_p[i] <= sync_p[i-1];
      d1 <= sync_q;
    end
  end

  assign sync_q = sync_p[SYNC_STAGES-1];

  // The chain comes out of reset at 0, so a pin held high through reset
  // would look like a rising edge; edges are ignored until the chain and d1
  // have been refilled with real pin values.
  always_ff @(posedge clk) begin
    if (reset)
      warm_cnt <= '0;
    else if (warm_cnt != WARM_DONE)
      warm_cnt <= warm_cnt + CNT_W'(1);
  end

  assign warm_done = (warm_cnt == WARM_DONE);

  always_comb begin
    edge_raw = '0;
    case (EDGE_TYPE)
      0:       edge_raw = sync_q & ~d1;
      1:       edge_raw = ~sync_q & d1;
      default: edge_raw = sync_q ^ d1;
    endcase
  end

  assign edge_det = warm_done ? edge_raw : '0;

  assign wr_mask = chipselect & ~write_n & (address == 2'd2);
  assign wr_edge = chipselect & ~write_n & (address == 2'd3);
  assign rd_en   = chipselect & ~read_n;
  assign clr     = wr_edge ? writedata[WIDTH-1:0] : '0;

  // Capture / mask / read registers. A new edge wins over a clear on the
  // same bit so that no edge is ever lost.
  always_ff @(posedge clk) begin
    if (reset) begin
      edge_cap <= '0;
      mask_q   <= '0;
      readdata <= '0;
    end else begin
      edge_cap <= edge_det | (edge_cap & ~clr);
      if (wr_mask)
        mask_q <= writedata[WIDTH-1:0];
      if (rd_en)
        readdata <= rd_sel(address, sync_q, mask_q, edge_cap);
    end
  end

  assign irq = |(edge_cap & mask_q);

endmodule
